// File: rtl/div_requester.sv
// Host-side front end for the sequential 10-bit divider: request FIFO, start/hold handshake, result capture.
// Define DIVREQ_TIMEOUT_EN to compile in the WAIT timeout counter and the DRAIN recovery state.
module div_requester #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 63
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [9:0] req_a,
   input  logic [9:0] req_b,
   output logic       div_start,
   output logic [9:0] div_a,
   output logic [9:0] div_b,
   input  logic       div_busy,
   input  logic       div_valid,
   input  logic       div_ovf,
   input  logic       div_dvz,
   input  logic [9:0] div_q,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [9:0] rsp_q,
   output logic [1:0] rsp_status
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DRAIN = 2'd3
   } state_t;

   state_t      state;
   logic [19:0] mem [DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic [19:0] head;
   logic        empty;
   logic        full;
   logic        push;
   logic        pop;
   logic        done;

   // Both host ports are valid/ready: a transfer happens on the rising edge where
   // valid and ready are both high; the offering side holds its data until then.
   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign req_ready = !full;
   assign push      = req_valid && !full;
   assign pop       = (state == IDLE) && !empty && (!rsp_valid || rsp_ready) && !div_busy;
   assign head      = mem[rd_ptr[AW-1:0]];
   assign done      = div_valid | div_ovf | div_dvz;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= {req_a, req_b};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

`ifdef DIVREQ_TIMEOUT_EN
   localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);
   logic [TW-1:0] tcnt;
`else
   logic unused_timeout;
   assign unused_timeout = |TIMEOUT;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         div_start  <= 1'b0;
         div_a      <= '0;
         div_b      <= '0;
         rsp_valid  <= 1'b0;
         rsp_q      <= '0;
         rsp_status <= 2'b00;
`ifdef DIVREQ_TIMEOUT_EN
         tcnt       <= '0;
`endif
      end else begin
         div_start <= 1'b0;
         if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (pop) begin
                  {div_a, div_b} <= head;
                  div_start      <= 1'b1;
                  state          <= ISSUE;
               end
            end
            ISSUE: begin
               state <= WAIT;
`ifdef DIVREQ_TIMEOUT_EN
               tcnt  <= '0;
`endif
            end
            WAIT: begin
               // A completion pulse beats an expiring timeout in the same cycle.
               if (done) begin
                  rsp_valid <= 1'b1;
                  state     <= IDLE;
                  if (div_dvz) begin
                     rsp_q      <= '0;
                     rsp_status <= 2'b10;
                  end else if (div_ovf) begin
                     rsp_q      <= '0;
                     rsp_status <= 2'b01;
                  end else begin
                     rsp_q      <= div_q;
                     rsp_status <= 2'b00;
                  end
               end
`ifdef DIVREQ_TIMEOUT_EN
               else if (tcnt == TMAX) begin
                  rsp_valid  <= 1'b1;
                  rsp_q      <= '0;
                  rsp_status <= 2'b11;
                  state      <= DRAIN;
               end else begin
                  tcnt <= tcnt + TW'(1);
               end
`endif
            end
`ifdef DIVREQ_TIMEOUT_EN
            DRAIN: begin
               if (!div_busy) state <= IDLE;
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

endmodule
